// File: rtl/uart_tx_feeder_if.sv
// Byte-feeder bus: CPU-side write port, status flags and the uart_send launch pair.
interface uart_tx_feeder_if #(
   parameter int unsigned DEPTH_LOG2 = 4
);
   logic                  wr_en;
   logic [7:0]            wr_data;
   logic                  clr_err;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DEPTH_LOG2:0]   fifo_count;
   logic                  overflow;
   logic                  timeout_err;
   logic                  tx_idle;
   logic                  uart_en;
   logic [7:0]            uart_din;
   logic                  uart_tx_busy;

   // Environment side: the CPU writing bytes plus uart_send reporting busy.
   modport master (
      output wr_en, wr_data, clr_err, uart_tx_busy,
      input  fifo_full, fifo_empty, fifo_count, overflow, timeout_err, tx_idle,
             uart_en, uart_din
   );

   // Feeder side.
   modport slave (
      input  wr_en, wr_data, clr_err, uart_tx_busy,
      output fifo_full, fifo_empty, fifo_count, overflow, timeout_err, tx_idle,
             uart_en, uart_din
   );
endinterface

// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of uart_send: launches one frame at a time as a rising edge
// on uart_en, waits for the frame to finish, then enforces an idle gap.
module uart_tx_feeder #(
   parameter int unsigned DEPTH_LOG2     = 4,
   parameter int unsigned GAP_CYCLES     = 16,
   parameter int unsigned LAUNCH_TIMEOUT = 64
) (
   input  logic            sys_clk,
   input  logic            sys_rst,
   uart_tx_feeder_if.slave bus
);
   localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
   localparam int unsigned TW    = $clog2(LAUNCH_TIMEOUT) + 1;
   localparam int unsigned GW    = $clog2(GAP_CYCLES) + 1;
   localparam int unsigned CW    = DEPTH_LOG2 + 1;

   localparam logic [TW-1:0]         TIMEOUT_LAST = TW'(LAUNCH_TIMEOUT - 1);
   localparam logic [GW-1:0]         GAP_LAST     = GW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0]         COUNT_FULL   = CW'(DEPTH);
   localparam logic [CW-1:0]         COUNT_ONE    = CW'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE      = DEPTH_LOG2'(1);
   localparam logic [TW-1:0]         TCNT_ONE     = TW'(1);
   localparam logic [GW-1:0]         GCNT_ONE     = GW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_DONE,
      S_GAP
   } state_e;

   state_e                 state_q, state_d;
   logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   full_q, full_d;
   logic                   empty_q, empty_d;
   logic                   overflow_q, overflow_d;
   logic                   timeout_err_q, timeout_err_d;
   logic                   uart_en_q, uart_en_d;
   logic [7:0]             uart_din_q, uart_din_d;
   logic [TW-1:0]          tcnt_q, tcnt_d;
   logic [GW-1:0]          gcnt_q, gcnt_d;
   logic                   push;
   logic                   pop;
   logic                   timeout_hit;
   logic [7:0]             mem [DEPTH];

   // FIFO bookkeeping and sticky error flags; a pop frees a slot, so a write while full is still legal then.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      push          = bus.wr_en && (!full_q || pop);
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      overflow_d    = overflow_q;
      timeout_err_d = timeout_err_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !pop)      count_d = count_q + COUNT_ONE;
      else if (pop && !push) count_d = count_q - COUNT_ONE;
      full_d  = (count_d == COUNT_FULL);
      empty_d = (count_d == '0);
      // Clear first so a same-cycle set event overrides it.
      if (bus.clr_err) begin
         overflow_d    = 1'b0;
         timeout_err_d = 1'b0;
      end
      if (bus.wr_en && !push) overflow_d    = 1'b1;
      if (timeout_hit)        timeout_err_d = 1'b1;
   end

   // FIFO pointer, occupancy and error-flag registers.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      // NOTE: clocked blocks use non-blocking assignments only, so every flop samples pre-edge values.
      if (sys_rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         full_q        <= 1'b0;
         empty_q       <= 1'b1;
         overflow_q    <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         full_q        <= full_d;
         empty_q       <= empty_d;
         overflow_q    <= overflow_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Byte storage; the pointers and count alone decide which entries are valid.
   always_ff @(posedge sys_clk) begin
      // NOTE: storage is deliberately not reset; resetting the pointers discards its contents.
      if (push) mem[wr_ptr_q] <= bus.wr_data;
   end

   // FSM state register together with its registered outputs and counters.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= S_IDLE;
         uart_en_q  <= 1'b0;
         uart_din_q <= 8'h00;
         tcnt_q     <= '0;
         gcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         uart_en_q  <= uart_en_d;
         uart_din_q <= uart_din_d;
         tcnt_q     <= tcnt_d;
         gcnt_q     <= gcnt_d;
      end
   end

   // Next-state: launch when data waits, leave LAUNCH on busy or timeout, gap after every frame.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (!empty_q) state_d = S_LAUNCH;
         S_LAUNCH: begin
            if (bus.uart_tx_busy)          state_d = S_WAIT_DONE;
            else if (tcnt_q == TIMEOUT_LAST) state_d = S_GAP;
         end
         S_WAIT_DONE: if (!bus.uart_tx_busy) state_d = S_GAP;
         S_GAP:       if (gcnt_q == GAP_LAST) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Output logic: next values of uart_en/uart_din, the pop strobe and both counters.
   always_comb begin
      pop         = 1'b0;
      timeout_hit = 1'b0;
      uart_en_d   = uart_en_q;
      uart_din_d  = uart_din_q;
      tcnt_d      = tcnt_q;
      gcnt_d      = gcnt_q;
      case (state_q)
         S_IDLE: begin
            if (!empty_q) begin
               pop        = 1'b1;
               uart_din_d = mem[rd_ptr_q];
               uart_en_d  = 1'b1;
               tcnt_d     = '0;
            end
         end
         S_LAUNCH: begin
            if (bus.uart_tx_busy) begin
               uart_en_d = 1'b0;
            end else if (tcnt_q == TIMEOUT_LAST) begin
               // Abandon the byte: downstream never answered.
               uart_en_d   = 1'b0;
               timeout_hit = 1'b1;
               gcnt_d      = '0;
            end else begin
               tcnt_d = tcnt_q + TCNT_ONE;
            end
         end
         S_WAIT_DONE: begin
            uart_en_d = 1'b0;
            if (!bus.uart_tx_busy) gcnt_d = '0;
         end
         S_GAP: begin
            // Keeps uart_en low long enough for uart_send's edge detector to re-arm.
            uart_en_d = 1'b0;
            gcnt_d    = gcnt_q + GCNT_ONE;
         end
         default: uart_en_d = 1'b0;
      endcase
   end

   assign bus.fifo_full   = full_q;
   assign bus.fifo_empty  = empty_q;
   assign bus.fifo_count  = count_q;
   assign bus.overflow    = overflow_q;
   assign bus.timeout_err = timeout_err_q;
   assign bus.tx_idle     = (state_q == S_IDLE) && empty_q;
   assign bus.uart_en     = uart_en_q;
   assign bus.uart_din    = uart_din_q;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a deadline-based reference model checked every cycle,
// a uart_send stand-in that answers launches, and directed scenarios with literal expectations.
module tb_uart_tx_feeder;
   localparam int DEPTH_LOG2 = 4;
   localparam int DEPTH      = 1 << DEPTH_LOG2;
   localparam int GAP        = 16;
   localparam int TMO        = 64;
   localparam int FRAME      = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_feeder_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

   uart_tx_feeder #(
      .DEPTH_LOG2     (DEPTH_LOG2),
      .GAP_CYCLES     (GAP),
      .LAUNCH_TIMEOUT (TMO)
   ) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Bytes queue up in write order; a launch may happen once the previous frame's
   // deadline (ready_at, an edge number) has passed. Values describe outputs after edge m_edge.
   logic [7:0] m_q[$];
   int         m_edge, m_ready_at, m_launch_edge;
   bit         m_launching, m_waiting, m_en, m_ovf, m_terr;
   logic [7:0] m_din;

   task automatic model_reset();
      m_q.delete();
      m_edge = 0; m_ready_at = 0; m_launch_edge = 0;
      m_launching = 0; m_waiting = 0; m_en = 0; m_ovf = 0; m_terr = 0;
      m_din = 8'h00;
   endtask

   task automatic model_step(input bit wr, input logic [7:0] data, input bit clr, input bit busy);
      bit full_before, popped, accepted, terr_set;
      full_before = (m_q.size() == DEPTH);
      popped      = 0;
      terr_set    = 0;
      m_edge++;
      if (m_launching) begin
         if (busy) begin
            m_en = 0; m_launching = 0; m_waiting = 1;
         end else if (m_edge - m_launch_edge == TMO) begin
            m_en = 0; m_launching = 0; terr_set = 1;
            m_ready_at = m_edge + GAP + 1;
         end
      end else if (m_waiting) begin
         if (!busy) begin
            m_waiting  = 0;
            m_ready_at = m_edge + GAP + 1;
         end
      end else if (m_edge >= m_ready_at && m_q.size() > 0) begin
         popped        = 1;
         m_din         = m_q.pop_front();
         m_en          = 1;
         m_launching   = 1;
         m_launch_edge = m_edge;
      end
      accepted = wr && (!full_before || popped);
      if (accepted) m_q.push_back(data);
      if (clr) begin m_ovf = 0; m_terr = 0; end
      if (wr && !accepted) m_ovf = 1;
      if (terr_set) m_terr = 1;
   endtask

   // Sample inputs at the edge, advance the model, compare all outputs just after the edge.
   initial begin
      bit s_rst, s_wr, s_clr, s_busy;
      logic [7:0] s_data;
      bit m_idle;
      model_reset();
      forever begin
         @(posedge clk);
         s_rst = rst; s_wr = bus.wr_en; s_data = bus.wr_data;
         s_clr = bus.clr_err; s_busy = bus.uart_tx_busy;
         if (s_rst) model_reset();
         else model_step(s_wr, s_data, s_clr, s_busy);
         #1;
         m_idle = !m_launching && !m_waiting && (m_edge >= m_ready_at - 1) && (m_q.size() == 0);
         check("cyc_fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
         check("cyc_fifo_full",  32'(bus.fifo_full),  32'(m_q.size() == DEPTH));
         check("cyc_fifo_empty", 32'(bus.fifo_empty), 32'(m_q.size() == 0));
         check("cyc_overflow",   32'(bus.overflow),   32'(m_ovf));
         check("cyc_timeout",    32'(bus.timeout_err), 32'(m_terr));
         check("cyc_tx_idle",    32'(bus.tx_idle),    32'(m_idle));
         check("cyc_uart_en",    32'(bus.uart_en),    32'(m_en));
         check("cyc_uart_din",   32'(bus.uart_din),   32'(m_din));
      end
   end

   // ---------------- uart_send stand-in ----------------
   // Two-flop edge detect on uart_en; on a rise it captures uart_din and stays busy for FRAME clocks.
   bit         resp_on = 1;
   logic [7:0] rx_q[$];
   bit         r_s1, r_s2;
   int         r_cnt;

   initial begin
      bus.uart_tx_busy = 1'b0;
      r_s1 = 0; r_s2 = 0; r_cnt = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.uart_tx_busy = 1'b0; r_s1 = 0; r_s2 = 0; r_cnt = 0;
         end else begin
            r_s2 = r_s1;
            r_s1 = bus.uart_en;
            if (bus.uart_tx_busy) begin
               r_cnt--;
               if (r_cnt == 0) bus.uart_tx_busy = 1'b0;
            end else if (resp_on && r_s1 && !r_s2) begin
               rx_q.push_back(bus.uart_din);
               bus.uart_tx_busy = 1'b1;
               r_cnt = FRAME;
            end
         end
      end
   end

   // ---------------- directed scenarios ----------------
   task automatic send_burst(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.wr_en   = 1'b1;
         bus.wr_data = first + 8'(i);
      end
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!bus.tx_idle && n < budget);
      check(name, 32'(bus.tx_idle), 1);
   endtask

   task automatic pulse_clr();
      @(negedge clk); bus.clr_err = 1'b1;
      @(negedge clk); bus.clr_err = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, gap, hi, lo, n, seen;
      bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.clr_err = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state.
      @(negedge clk);
      check("rst_fifo_empty",  32'(bus.fifo_empty), 1);
      check("rst_fifo_full",   32'(bus.fifo_full), 0);
      check("rst_fifo_count",  32'(bus.fifo_count), 0);
      check("rst_uart_en",     32'(bus.uart_en), 0);
      check("rst_uart_din",    32'(bus.uart_din), 0);
      check("rst_tx_idle",     32'(bus.tx_idle), 1);
      check("rst_overflow",    32'(bus.overflow), 0);
      check("rst_timeout_err", 32'(bus.timeout_err), 0);

      // Single byte: uart_en rises two edges after the write, idle returns GAP clocks after busy falls.
      rx_q.delete();
      bus.wr_en = 1'b1; bus.wr_data = 8'h55;
      lat = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         bus.wr_en = 1'b0;
         lat++;
         if (bus.uart_en) break;
      end
      check("single_en_latency", 32'(lat), 2);
      check("single_launch_din", 32'(bus.uart_din), 32'h55);
      n = 0;
      while (!bus.uart_tx_busy && n < 100) begin @(posedge clk); #1; n++; end
      check("single_busy_rise", 32'(bus.uart_tx_busy), 1);
      check("single_en_dropped", 32'(bus.uart_en), 0);
      n = 0;
      while (bus.uart_tx_busy && n < 200) begin @(posedge clk); #1; n++; end
      check("single_busy_fall", 32'(bus.uart_tx_busy), 0);
      gap = 0;
      do begin @(posedge clk); #1; gap++; end while (!bus.tx_idle && gap < 100);
      check("single_gap_to_idle", 32'(gap), GAP);
      check("single_rx_count", 32'(rx_q.size()), 1);
      if (rx_q.size() > 0) check("single_rx_byte", 32'(rx_q[0]), 32'h55);

      // Burst of 17: one byte is popped early, so the 17th write fills the FIFO.
      rx_q.delete();
      send_burst(8'h00, 17);
      check("burst_full",     32'(bus.fifo_full), 1);
      check("burst_count",    32'(bus.fifo_count), 16);
      check("burst_overflow", 32'(bus.overflow), 0);
      wait_idle("burst_drain", 3000);
      check("burst_rx_count", 32'(rx_q.size()), 17);
      foreach (rx_q[i]) check("burst_rx_order", 32'(rx_q[i]), 32'(i));

      // Burst of 18: only the 18th byte arrives while full and is dropped.
      rx_q.delete();
      send_burst(8'h20, 18);
      check("ovf_flag",  32'(bus.overflow), 1);
      check("ovf_count", 32'(bus.fifo_count), 16);
      pulse_clr();
      check("ovf_cleared", 32'(bus.overflow), 0);
      wait_idle("ovf_drain", 3000);
      check("ovf_rx_count", 32'(rx_q.size()), 17);
      foreach (rx_q[i]) check("ovf_rx_order", 32'(rx_q[i]), 32'h20 + 32'(i));

      // Downstream silent: 0xA5 times out after 64 clocks, 0x5A launches after the gap.
      rx_q.delete();
      resp_on = 0;
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_data = 8'hA5;
      hi = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (i == 0) bus.wr_data = 8'h5A;
         else if (i == 1) bus.wr_en = 1'b0;
         if (bus.uart_en) hi++;
         else if (hi > 0) break;
      end
      check("tmo_en_high_cycles", 32'(hi), TMO);
      check("tmo_err_set",   32'(bus.timeout_err), 1);
      check("tmo_en_low",    32'(bus.uart_en), 0);
      check("tmo_not_stall", 32'(bus.fifo_count), 1);
      resp_on = 1;
      lo = 1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (bus.uart_en) break;
         lo++;
      end
      check("tmo_gap_low_cycles", 32'(lo), GAP + 1);
      check("tmo_next_din", 32'(bus.uart_din), 32'h5A);
      pulse_clr();
      check("tmo_err_cleared", 32'(bus.timeout_err), 0);
      wait_idle("tmo_drain", 500);
      check("tmo_rx_count", 32'(rx_q.size()), 1);
      if (rx_q.size() > 0) check("tmo_rx_byte", 32'(rx_q[0]), 32'h5A);

      // Reset while a byte is being launched with more queued.
      rx_q.delete();
      resp_on = 0;
      send_burst(8'h11, 3);
      check("rst_mid_launching", 32'(bus.uart_en), 1);
      rst = 1'b1;
      #1;
      check("rst_mid_en",    32'(bus.uart_en), 0);
      check("rst_mid_count", 32'(bus.fifo_count), 0);
      check("rst_mid_idle",  32'(bus.tx_idle), 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      resp_on = 1;
      seen = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (bus.uart_en) seen++;
      end
      check("rst_mid_no_tx", 32'(seen), 0);
      check("rst_mid_rx",    32'(rx_q.size()), 0);

      // Write and pop on the same edge while full: accepted, no overflow, byte goes out last.
      rx_q.delete();
      send_burst(8'h40, 17);
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!(!m_launching && !m_waiting && (m_edge + 1 >= m_ready_at) && m_q.size() > 0) && n < 200);
      check("wp_pop_predicted", 32'(n < 200), 1);
      check("wp_full_before",   32'(bus.fifo_full), 1);
      bus.wr_en = 1'b1; bus.wr_data = 8'h77;
      @(negedge clk);
      bus.wr_en = 1'b0;
      check("wp_count",    32'(bus.fifo_count), 16);
      check("wp_overflow", 32'(bus.overflow), 0);
      check("wp_launched", 32'(bus.uart_en), 1);
      wait_idle("wp_drain", 3000);
      check("wp_rx_count", 32'(rx_q.size()), 18);
      for (int i = 0; i < 17 && i < rx_q.size(); i++) check("wp_rx_order", 32'(rx_q[i]), 32'h40 + 32'(i));
      if (rx_q.size() == 18) check("wp_rx_last", 32'(rx_q[17]), 32'h77);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
